// File: rtl/nios2_dbg_ocimem_ctrl_if.sv
// Bus bundle between the JTAG debug-slave stage, the OCI memory controller
// and the on-chip debug memory. The controller connects through the slave
// modport; whatever drives commands and models memory uses the master side.
interface nios2_dbg_ocimem_ctrl_if;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic [9:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output mem_readdata, mem_waitrequest,
    input  mem_address, mem_read, mem_write, mem_writedata,
    input  MonDReg, monitor_ready, monitor_error
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  mem_readdata, mem_waitrequest,
    output mem_address, mem_read, mem_write, mem_writedata,
    output MonDReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/nios2_dbg_ocimem_ctrl.sv
// Nios II debug OCI memory controller: turns JTAG monitor commands into
// single-word reads/writes of the debug memory, with address auto-increment,
// a waitrequest timeout and a sticky error flag. All outputs are registered.
module nios2_dbg_ocimem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_PATTERN    = 32'hDEADBEEF
) (
  input logic                    clk,
  input logic                    reset_n,
  nios2_dbg_ocimem_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc_s;
  logic        any_strobe_s;
  logic        jdo_unused;

  // Word address advances modulo the 1024-word debug memory.
  function automatic logic [9:0] next_addr(input logic [9:0] a);
    return a + 10'd1;
  endfunction

  assign any_strobe_s = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a |
                        bus.take_action_ocimem_b;
  assign cnt_inc_s    = cnt_q + 8'd1;
  // jdo carries framing bits this block has no use for.
  assign jdo_unused   = ^{bus.jdo[37:35], bus.jdo[1:0]};

  // Command decode, access sequencing and timeout handling.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Strobe priority: address load, then auto-increment read, then write.
        if (bus.take_action_ocimem_a) begin
          addr_d = bus.jdo[11:2];
          err_d  = 1'b0;
          if (bus.jdo[17]) begin
            state_d = ST_RD;
            cnt_d   = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.take_no_action_ocimem_a) begin
          state_d = ST_RD;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end else if (bus.take_action_ocimem_b) begin
          data_d  = bus.jdo[34:3];
          state_d = ST_WR;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD, ST_WR: begin
        // A command while busy is dropped but flagged; the access carries on.
        if (any_strobe_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (!bus.mem_waitrequest) begin
          if (state_q == ST_RD) begin
            data_d = bus.mem_readdata;
          end else begin
            data_d = data_q;
          end
          addr_d  = next_addr(addr_q);
          state_d = ST_IDLE;
        end else if (cnt_inc_s == TIMEOUT_W) begin
          // Stalled too long: give up without advancing the address.
          cnt_d = cnt_inc_s;
          err_d = 1'b1;
          if (state_q == ST_RD) begin
            data_d = ERR_PATTERN;
          end else begin
            data_d = data_q;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rd_d    = (state_d == ST_RD);
    wr_d    = (state_d == ST_WR);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 10'd0;
      data_q  <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_address   = addr_q;
  assign bus.mem_read      = rd_q;
  assign bus.mem_write     = wr_q;
  assign bus.mem_writedata = data_q;
  assign bus.MonDReg       = data_q;
  assign bus.monitor_ready = ready_q;
  assign bus.monitor_error = err_q;

endmodule

// File: tb/tb_nios2_dbg_ocimem_ctrl.sv
// Testbench for nios2_dbg_ocimem_ctrl: directed scenarios followed by random
// commands, checked against a transaction-level model of the monitor.
module tb_nios2_dbg_ocimem_ctrl;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  nios2_dbg_ocimem_ctrl_if bif();

  nios2_dbg_ocimem_ctrl #(
    .TIMEOUT_CYCLES(255),
    .ERR_PATTERN(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bif)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_arr [1024];
  logic [9:0]  m_addr;
  logic [31:0] m_data;
  logic        m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_strb(input logic [2:0] s);
    bif.take_action_ocimem_a    = s[2];
    bif.take_no_action_ocimem_a = s[1];
    bif.take_action_ocimem_b    = s[0];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, bif.monitor_ready, 1'b1);
    check({tag, "_read"},  bif.mem_read, 1'b0);
    check({tag, "_write"}, bif.mem_write, 1'b0);
    check({tag, "_addr"},  bif.mem_address, m_addr);
    check({tag, "_mond"},  bif.MonDReg, m_data);
    check({tag, "_wdata"}, bif.mem_writedata, m_data);
    check({tag, "_err"},   bif.monitor_error, m_err);
  endtask

  // One command with a memory that stalls 'waits' cycles; optionally a
  // stray strobe set 'inj_strb' is injected during access cycle 'inj'.
  task automatic do_cmd(input string tag, input logic [2:0] strb, input logic [37:0] j,
                        input int waits, input int inj, input logic [2:0] inj_strb);
    logic       goes;
    logic       is_rd;
    logic [9:0] acc_addr;
    goes  = 1'b0;
    is_rd = 1'b0;
    if (strb[2]) begin
      m_addr = j[11:2];
      goes   = j[17];
      is_rd  = 1'b1;
    end else if (strb[1]) begin
      goes  = 1'b1;
      is_rd = 1'b1;
    end else begin
      m_data = j[34:3];
      goes   = 1'b1;
    end
    m_err = 1'b0;
    bif.jdo = j;
    set_strb(strb);
    tick();
    set_strb(3'b000);
    if (!goes) begin
      check_idle({tag, "_load"});
      return;
    end
    check({tag, "_busy"},   bif.monitor_ready, 1'b0);
    check({tag, "_errclr"}, bif.monitor_error, 1'b0);
    acc_addr = m_addr;
    for (int n = 0; n <= waits; n++) begin
      set_strb(3'b000);
      bif.mem_waitrequest = (n < waits);
      bif.mem_readdata    = mem_arr[acc_addr];
      if (n == inj) begin
        bif.jdo = {6'($urandom), 32'($urandom)};
        set_strb(inj_strb);
        m_err = 1'b1;
      end
      check({tag, "_rdreq"}, bif.mem_read, is_rd);
      check({tag, "_wrreq"}, bif.mem_write, !is_rd);
      check({tag, "_aaddr"}, bif.mem_address, acc_addr);
      if (!is_rd) check({tag, "_awdata"}, bif.mem_writedata, m_data);
      tick();
    end
    set_strb(3'b000);
    bif.mem_waitrequest = 1'b0;
    if (is_rd) m_data = mem_arr[acc_addr];
    else       mem_arr[acc_addr] = m_data;
    m_addr = acc_addr + 10'd1;
    check_idle({tag, "_done"});
  endtask

  initial begin
    logic [37:0] j;
    logic [2:0]  s;
    int          w;
    int          inj;

    for (int i = 0; i < 1024; i++) mem_arr[i] = $urandom;
    bif.jdo = 38'd0;
    set_strb(3'b000);
    bif.mem_readdata    = 32'd0;
    bif.mem_waitrequest = 1'b0;
    reset_n = 1'b0;
    m_addr = 10'd0;
    m_data = 32'd0;
    m_err  = 1'b0;
    tick();
    tick();
    check_idle("reset");
    reset_n = 1'b1;
    tick();

    // Address load with immediate read, zero-wait memory.
    mem_arr[10'h040] = 32'h12345678;
    j = 38'd0;
    j[11:2] = 10'h040;
    j[17]   = 1'b1;
    do_cmd("ld_rd", 3'b100, j, 0, -1, 3'b000);
    check("ld_rd_val", bif.MonDReg, 32'h12345678);

    // Write at the top address wraps the address to zero.
    j = 38'd0;
    j[11:2] = 10'h3FF;
    do_cmd("ld3ff", 3'b100, j, 0, -1, 3'b000);
    j = 38'd0;
    j[34:3] = 32'hCAFEF00D;
    do_cmd("wr_wrap", 3'b001, j, 3, -1, 3'b000);
    check("wr_wrap_addr", bif.mem_address, 10'h000);

    // Three auto-increment reads starting at 0x010.
    j = 38'd0;
    j[11:2] = 10'h010;
    do_cmd("ld010", 3'b100, j, 0, -1, 3'b000);
    do_cmd("inc0", 3'b010, 38'd0, 1, -1, 3'b000);
    do_cmd("inc1", 3'b010, 38'd0, 0, -1, 3'b000);
    do_cmd("inc2", 3'b010, 38'd0, 2, -1, 3'b000);
    check("inc_final", bif.mem_address, 10'h013);

    // Stuck waitrequest on a read aborts after 255 stalled cycles.
    bif.jdo = 38'd0;
    set_strb(3'b010);
    tick();
    set_strb(3'b000);
    bif.mem_waitrequest = 1'b1;
    for (int n = 0; n < 255; n++) begin
      check("to_hold", bif.mem_read, 1'b1);
      tick();
    end
    bif.mem_waitrequest = 1'b0;
    m_data = 32'hDEADBEEF;
    m_err  = 1'b1;
    check_idle("timeout");
    do_cmd("after_to", 3'b010, 38'd0, 0, -1, 3'b000);

    // Write strobe during a read stall is ignored but flagged.
    do_cmd("busy_b", 3'b010, 38'd0, 3, 1, 3'b001);

    // Simultaneous strobes resolve by priority.
    j = {6'($urandom), 32'($urandom)};
    j[17] = 1'b1;
    do_cmd("pri_all", 3'b111, j, 1, -1, 3'b000);
    do_cmd("pri_nb", 3'b011, {6'($urandom), 32'($urandom)}, 0, -1, 3'b000);
    j[17] = 1'b0;
    do_cmd("pri_a_only", 3'b101, j, 0, -1, 3'b000);

    // Reset in the middle of a stalled write.
    bif.jdo = {3'b000, 32'h5555AAAA, 3'b000};
    set_strb(3'b001);
    tick();
    set_strb(3'b000);
    bif.mem_waitrequest = 1'b1;
    tick();
    tick();
    check("rst_wr_pre", bif.mem_write, 1'b1);
    reset_n = 1'b0;
    tick();
    m_addr = 10'd0;
    m_data = 32'd0;
    m_err  = 1'b0;
    check_idle("rst_wr");
    reset_n = 1'b1;
    bif.mem_waitrequest = 1'b0;
    tick();

    // Random command mix.
    for (int k = 0; k < 40; k++) begin
      s   = 3'($urandom_range(1, 7));
      j   = {6'($urandom), 32'($urandom)};
      w   = $urandom_range(0, 4);
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w) : -1;
      do_cmd("rnd", s, j, w, inj, 3'($urandom_range(1, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
